// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - 8N1 UART transmitter for a latched 1..NUM_BYTES byte payload
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 583,
    parameter int NUM_BYTES    = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tx_start,
    input  logic [2:0]             tx_len,
    input  logic [8*NUM_BYTES-1:0] tx_data,
    output logic                   txd,
    output logic                   tx_busy,
    output logic                   byte_done,
    output logic                   tx_done
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     MAX_LEN  = 3'(NUM_BYTES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                 state;
    logic [CW-1:0]          clk_cnt;
    logic [2:0]             bit_idx;
    logic [2:0]             bytes_left;
    logic [8*NUM_BYTES-1:0] shreg;
    logic [2:0]             eff_len;
    logic                   bit_end;

    // Requested length clamped to the payload width; zero means "no request"
    always_comb begin
        eff_len = tx_len;
        if (tx_len > MAX_LEN) begin
            eff_len = MAX_LEN;
        end
    end

    assign bit_end = (clk_cnt == BIT_LAST);

    // Frame sequencer: txd and handshake outputs are registered alongside the state.
    // The shift register moves one bit per data bit, so after each byte the next
    // byte of the payload sits in the low bits ready to go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            bytes_left <= '0;
            shreg      <= '0;
            txd        <= 1'b1;
            tx_busy    <= 1'b0;
            byte_done  <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            tx_done   <= 1'b0;
            case (state)
                IDLE: begin
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (tx_start && (eff_len != 3'd0)) begin
                        shreg      <= tx_data;
                        bytes_left <= eff_len;
                        state      <= START;
                        txd        <= 1'b0;
                        tx_busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        txd     <= shreg[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        shreg   <= shreg >> 1;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            txd     <= shreg[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt    <= '0;
                        byte_done  <= 1'b1;
                        bytes_left <= bytes_left - 1'b1;
                        if (bytes_left == 3'd1) begin
                            txd     <= 1'b1;
                            tx_busy <= 1'b0;
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            // Next start bit follows the stop bit with no idle gap
                            txd   <= 1'b0;
                            state <= START;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    txd     <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame
module tb_uart_tx_frame;

    localparam int CPB   = 16;
    localparam int CPB_B = 583;
    localparam int NB    = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start_a = 1'b0;
    logic [2:0]    len_a = 3'd0;
    logic [8*NB-1:0] data_a = '0;
    logic          txd_a, busy_a, bd_a, done_a;

    logic          start_b = 1'b0;
    logic [2:0]    len_b = 3'd0;
    logic [8*NB-1:0] data_b = '0;
    logic          txd_b, busy_b, bd_b, done_b;

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .NUM_BYTES(NB)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_start(start_a), .tx_len(len_a), .tx_data(data_a),
        .txd(txd_a), .tx_busy(busy_a), .byte_done(bd_a), .tx_done(done_a)
    );

    uart_tx_frame #(.NUM_BYTES(NB)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_start(start_b), .tx_len(len_b), .tx_data(data_b),
        .txd(txd_b), .tx_busy(busy_b), .byte_done(bd_b), .tx_done(done_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse tx_start on dut_a, queue the bytes it should emit, check the start-bit latency
    task automatic send_a(input logic [2:0] len, input logic [8*NB-1:0] data);
        int n;
        @(negedge clk);
        start_a = 1'b1;
        len_a   = len;
        data_a  = data;
        n = (int'(len) > NB) ? NB : int'(len);
        for (int i = 0; i < n; i++) exp_q.push_back(data[8*i +: 8]);
        @(negedge clk);
        start_a = 1'b0;
        chk("start_latency_txd", 32'(txd_a), 0);
        chk("start_latency_busy", 32'(busy_a), 1);
    endtask

    // 8N1 receiver model for dut_a: entered at the negedge where the start bit is first seen
    task automatic recv_a(input int n);
        int fall, first, t;
        logic [7:0] b, e;
        t = 0;
        while (txd_a !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("rx_start_seen", 32'(txd_a), 0);
        first = cyc;
        fall  = cyc;
        for (int k = 0; k < n; k++) begin
            repeat (CPB / 2 - 1) @(negedge clk);
            chk("rx_start_bit", 32'(txd_a), 0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = txd_a;
            end
            repeat (CPB) @(negedge clk);
            chk("rx_stop_bit", 32'(txd_a), 1);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            chk("rx_byte", 32'(b), 32'(e));
            t = 0;
            while (bd_a !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk("byte_done_period", cyc - fall, 10 * CPB);
            if (k == n - 1) begin
                chk("tx_done_with_last_byte", 32'(done_a), 1);
                chk("frame_duration", cyc - first, 10 * CPB * n);
                chk("busy_clear_at_done", 32'(busy_a), 0);
            end else begin
                chk("no_done_mid_frame", 32'(done_a), 0);
                chk("no_gap_next_start", 32'(txd_a), 0);
                fall = cyc;
            end
        end
    endtask

    // Length of the current txd_b run in cycles, starting at the current negedge
    task automatic run_b(input logic v, output int n);
        n = 0;
        while (txd_b === v && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int bad, t, fall, r;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_txd", 32'(txd_a), 1);
        chk("reset_busy", 32'(busy_a), 0);
        chk("reset_byte_done", 32'(bd_a), 0);
        chk("reset_tx_done", 32'(done_a), 0);
        chk("reset_txd_b", 32'(txd_b), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0x55
        send_a(3'd1, 48'h55);
        recv_a(1);

        // Full six-byte payload
        repeat (5) @(negedge clk);
        send_a(3'd6, 48'hABCDEF012345);
        recv_a(6);

        // tx_start held high: back-to-back frames, mid-frame input changes ignored
        repeat (5) @(negedge clk);
        start_a = 1'b1;
        len_a   = 3'd2;
        data_a  = 48'h00FF;
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00);
        @(negedge clk);
        chk("held_start_latency", 32'(txd_a), 0);
        recv_a(2);
        @(negedge clk);
        chk("b2b_second_start_txd", 32'(txd_a), 0);
        chk("b2b_second_start_busy", 32'(busy_a), 1);
        len_a  = 3'd1;
        data_a = 48'h1234;
        exp_q.push_back(8'h34);
        recv_a(2);
        @(negedge clk);
        chk("b2b_third_start_txd", 32'(txd_a), 0);
        start_a = 1'b0;
        recv_a(1);

        // Zero length is ignored
        repeat (5) @(negedge clk);
        start_a = 1'b1;
        len_a   = 3'd0;
        data_a  = 48'hFFFF;
        @(negedge clk);
        start_a = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (txd_a !== 1'b1 || busy_a !== 1'b0 || bd_a !== 1'b0 || done_a !== 1'b0) bad = 1;
            @(negedge clk);
        end
        chk("len0_ignored", bad, 0);

        // Length above NUM_BYTES clamps to six bytes
        send_a(3'd7, 48'h112233445566);
        recv_a(6);
        bad = 0;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk);
            if (txd_a !== 1'b1 || busy_a !== 1'b0 || bd_a !== 1'b0) bad = 1;
        end
        chk("len7_no_seventh_byte", bad, 0);

        // Reset during bit 3 of byte 1
        send_a(3'd2, 48'h0);
        exp_q.delete();
        repeat (10 * CPB + 4 * CPB + CPB / 2) @(negedge clk);
        chk("pre_reset_txd_low", 32'(txd_a), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mid_txd", 32'(txd_a), 1);
        chk("reset_mid_busy", 32'(busy_a), 0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bd_a !== 1'b0 || done_a !== 1'b0 || txd_a !== 1'b1) bad = 1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20 * CPB; i++) begin
            @(negedge clk);
            if (bd_a !== 1'b0 || done_a !== 1'b0 || txd_a !== 1'b1 || busy_a !== 1'b0) bad = 1;
        end
        chk("reset_mid_no_pulses", bad, 0);
        send_a(3'd1, 48'hA5);
        recv_a(1);
        chk("scoreboard_empty", exp_q.size(), 0);

        // Default bit period, 0x3C: runs of 3 low, 4 high, 2 low bits, then stop
        @(negedge clk);
        start_b = 1'b1;
        len_b   = 3'd1;
        data_b  = 48'h3C;
        @(negedge clk);
        start_b = 1'b0;
        chk("b_start_latency", 32'(txd_b), 0);
        fall = cyc;
        run_b(1'b0, r);
        chk("b_run_low3", r, 3 * CPB_B);
        run_b(1'b1, r);
        chk("b_run_high4", r, 4 * CPB_B);
        run_b(1'b0, r);
        chk("b_run_low2", r, 2 * CPB_B);
        t = 0;
        while (done_b !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("b_frame_duration", cyc - fall, 10 * CPB_B);
        chk("b_byte_done_with_done", 32'(bd_b), 1);
        chk("b_txd_idle_after", 32'(txd_b), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
